// File: rtl/sram_access_ctrl.sv
// Initiator for a single-port SRAM macro: zero-fills the array after reset, then
// serves valid/ready read/write requests and returns read data through a response FIFO.
module sram_access_ctrl #(
  parameter int BITS       = 80,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int RESP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RSTB,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BITS-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [BITS-1:0]   resp_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [BITS-1:0]   sram_d,
  input  logic [BITS-1:0]   sram_q
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic [BITS-1:0]   fifo_mem [RESP_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       credit;
  logic              fire, rd_fire, push, pop;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST_ADDR) state_nxt = RUN;
  end

  // Credit covers buffered entries plus the read whose Q lands next edge,
  // minus the entry leaving this cycle, so a push never meets a full FIFO.
  assign resp_valid = (count != '0);
  assign resp_rdata = resp_valid ? fifo_mem[rd_ptr] : '0;
  assign pop        = resp_valid && resp_ready;
  assign credit     = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

  always_comb begin
    init_done = (state == RUN);
    req_ready = (state == RUN) && (credit < (CW+1)'(RESP_DEPTH));
    fire      = req_valid && req_ready;
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    if (RSTB) begin
      if (state == INIT) begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_a   = init_cnt;
      end else if (fire) begin
        sram_ceb = 1'b0;
        sram_web = ~req_write;
        sram_a   = req_addr;
        sram_d   = req_wdata;
      end
    end
  end

  assign rd_fire = fire && !req_write;
  assign push    = inflight;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)              init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + ADDR_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) inflight <= 1'b0;
    else       inflight <= rd_fire;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= sram_q;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTB)
    !(push && !pop && count == CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural SRAM macro that returns
// random Q on every non-read cycle and powers up with random contents.
module tb_sram_access_ctrl;
  localparam int BITS = 80, DEPTH = 32, ADDR_W = 5, RESP_DEPTH = 2;

  logic              CLK = 1'b0;
  logic              RSTB;
  logic              init_done, req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BITS-1:0]   req_wdata;
  logic              resp_valid, resp_ready;
  logic [BITS-1:0]   resp_rdata;
  logic              sram_ceb, sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [BITS-1:0]   sram_d, sram_q;

  int unsigned errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  sram_access_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESP_DEPTH(RESP_DEPTH)) dut (
    .CLK(CLK), .RSTB(RSTB), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  function automatic logic [BITS-1:0] rnd();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  logic [BITS-1:0] macro_mem [DEPTH];
  logic            seeded = 1'b0;

  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) macro_mem[i] <= rnd();
      seeded <= 1'b1;
    end else if (!sram_ceb && !sram_web) begin
      macro_mem[sram_a] <= sram_d;
    end
    if (!sram_ceb && sram_web) sram_q <= macro_mem[sram_a];
    else                       sram_q <= rnd();
  end

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered one time unit after the edge that opens the first sweep cycle.
  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      check("sweep_ceb", BITS'(sram_ceb), BITS'(0));
      check("sweep_web", BITS'(sram_web), BITS'(0));
      check("sweep_a", BITS'(sram_a), BITS'(i));
      check("sweep_d", sram_d, '0);
      check("sweep_done", BITS'(init_done), BITS'(0));
      check("sweep_rdy", BITS'(req_ready), BITS'(0));
      tick();
    end
    #2;
    check("init_done", BITS'(init_done), BITS'(1));
    check("run_rdy", BITS'(req_ready), BITS'(1));
  endtask

  logic [BITS-1:0] vals [8];
  int              exp_idx [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};
  bit              exp_rdy [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int              next_addr;

  initial begin
    RSTB = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) vals[i] = {16'(16'hA500 + i), 64'h0123_4567_89AB_CDEF ^ 64'(i)};

    // Reset state, then the zero-fill sweep
    tick(); tick();
    #2;
    check("rst_ceb", BITS'(sram_ceb), BITS'(1));
    check("rst_done", BITS'(init_done), BITS'(0));
    check("rst_rdy", BITS'(req_ready), BITS'(0));
    check("rst_valid", BITS'(resp_valid), BITS'(0));
    check("rst_rdata", resp_rdata, '0);
    tick();
    RSTB = 1'b1;
    sweep();
    tick();

    // Write 5, read 5 and 7 (7 must read back the zero fill)
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5; req_wdata = BITS'(80'hAB);
    #2;
    check("w5_rdy", BITS'(req_ready), BITS'(1));
    check("w5_ceb", BITS'(sram_ceb), BITS'(0));
    check("w5_web", BITS'(sram_web), BITS'(0));
    check("w5_a", BITS'(sram_a), BITS'(5));
    check("w5_d", sram_d, BITS'(80'hAB));
    tick();
    req_write = 1'b0; req_wdata = '0;
    #2;
    check("r5_ceb", BITS'(sram_ceb), BITS'(0));
    check("r5_web", BITS'(sram_web), BITS'(1));
    check("r5_valid", BITS'(resp_valid), BITS'(0));
    tick();
    req_addr = 7;
    #2;
    check("r7_a", BITS'(sram_a), BITS'(7));
    check("r5_lat1", BITS'(resp_valid), BITS'(0));
    check("r5_lat1_d", resp_rdata, '0);
    tick();
    req_valid = 1'b0;
    #2;
    check("idle_ceb", BITS'(sram_ceb), BITS'(1));
    check("idle_a", BITS'(sram_a), BITS'(0));
    check("r5_valid2", BITS'(resp_valid), BITS'(1));
    check("r5_data", resp_rdata, BITS'(80'hAB));
    tick();
    #2;
    check("r7_valid", BITS'(resp_valid), BITS'(1));
    check("r7_data", resp_rdata, '0);
    tick();
    #2;
    check("empty_valid", BITS'(resp_valid), BITS'(0));
    check("empty_rdata", resp_rdata, '0);
    tick();

    // Fill 0..7, then back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_W'(i); req_wdata = vals[i];
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8); req_write = 1'b0; req_addr = ADDR_W'(c); req_wdata = '0;
      #2;
      if (c < 8) check("b2b_rdy", BITS'(req_ready), BITS'(1));
      if (c >= 2) begin
        check("b2b_valid", BITS'(resp_valid), BITS'(1));
        check("b2b_data", resp_rdata, vals[c-2]);
      end else begin
        check("b2b_novalid", BITS'(resp_valid), BITS'(0));
      end
      tick();
    end
    #2;
    check("b2b_drained", BITS'(resp_valid), BITS'(0));
    tick();

    // Backpressure: two reads fire, stall, then drain and resume
    next_addr = 0;
    for (int c = 0; c < 10; c++) begin
      resp_ready = (c >= 5);
      req_valid  = (next_addr < 4);
      req_write  = 1'b0;
      req_addr   = ADDR_W'(next_addr);
      #2;
      check("bp_rdy", BITS'(req_ready), BITS'(exp_rdy[c]));
      if (exp_idx[c] < 0) begin
        check("bp_novalid", BITS'(resp_valid), BITS'(0));
      end else begin
        check("bp_valid", BITS'(resp_valid), BITS'(1));
        check("bp_data", resp_rdata, vals[exp_idx[c]]);
      end
      if (req_valid && exp_rdy[c]) next_addr++;
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;

    // Write then read the same address on the next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3; req_wdata = BITS'(80'h1234);
    #2;
    check("w3_rdy", BITS'(req_ready), BITS'(1));
    tick();
    req_write = 1'b0; req_wdata = '0;
    #2;
    check("r3_web", BITS'(sram_web), BITS'(1));
    tick();
    req_valid = 1'b0;
    #2;
    check("r3_lat1", BITS'(resp_valid), BITS'(0));
    tick();
    #2;
    check("r3_valid", BITS'(resp_valid), BITS'(1));
    check("r3_data", resp_rdata, BITS'(80'h1234));
    tick();

    // Reset with two responses buffered
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 0;
    tick();
    req_addr = 1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2;
    check("full_valid", BITS'(resp_valid), BITS'(1));
    check("full_data", resp_rdata, vals[0]);
    check("full_rdy", BITS'(req_ready), BITS'(0));
    RSTB = 1'b0;
    #1;
    check("mid_rst_valid", BITS'(resp_valid), BITS'(0));
    check("mid_rst_rdata", resp_rdata, '0);
    check("mid_rst_ceb", BITS'(sram_ceb), BITS'(1));
    check("mid_rst_done", BITS'(init_done), BITS'(0));
    check("mid_rst_rdy", BITS'(req_ready), BITS'(0));
    tick();
    RSTB = 1'b1; resp_ready = 1'b1;
    sweep();
    tick();
    req_valid = 1'b1; req_addr = 5;
    #2;
    check("post_rdy", BITS'(req_ready), BITS'(1));
    tick();
    req_valid = 1'b0;
    #2;
    check("post_lat1", BITS'(resp_valid), BITS'(0));
    tick();
    #2;
    check("post_valid", BITS'(resp_valid), BITS'(1));
    check("post_data", resp_rdata, '0);
    check("post_done", BITS'(init_done), BITS'(1));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
